// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB completer exposing NUM_REGS read/write registers,
// with programmable wait states, address-decode error reporting and a
// hardware-side write port for status updates.
// Optional feature macro: APB_REG_PSTRB_EN adds byte-lane write strobes (pstrb).
//
// Handshake: a transfer starts with a setup edge (psel=1, penable=0) seen in
// IDLE. It completes on the first edge where psel=1, penable=1 and pready=1.
// pready is only raised after WAIT_CYCLES access cycles. Dropping psel in
// ACCESS abandons the transfer without side effects. penable without a prior
// setup phase is not a transfer.
module apb_reg_completer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int BASE_ADDR   = 0,
  localparam int BSH        = $clog2(DATA_W / 8),
  localparam int IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_REG_PSTRB_EN
  input  logic [DATA_W/8-1:0]        pstrb,
`endif
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       perror,
  input  logic                       hw_we,
  input  logic [IW-1:0]              hw_idx,
  input  logic [DATA_W-1:0]          hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       dbg_state_o
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  localparam logic [3:0]        WAIT_C    = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << BSH) - 1);
  localparam logic [ADDR_W:0]   NREGS_A   = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [IW:0]       NREGS_I   = (IW + 1)'(NUM_REGS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [ADDR_W:0]   diff;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] word;
  logic [IW-1:0]     idx;
  logic              err;
  logic              commit;

  // Address decode: the extra borrow bit of the subtraction flags addresses below the base.
  always_comb begin
    diff = {1'b0, paddr} - {1'b0, BASE_A};
    off  = diff[ADDR_W-1:0];
    word = off >> BSH;
    err  = diff[ADDR_W] || ((off & LANE_MASK) != '0) || ({1'b0, word} >= NREGS_A);
    idx  = word[IW-1:0];
  end

  // Bus-facing outputs are combinational from registered state and APB inputs only.
  always_comb begin
    pready      = (state_q == S_ACCESS) && (cnt_q == WAIT_C) && psel && penable;
    perror      = pready && err;
    prdata      = (pready && !pwrite && !err) ? regs_q[idx] : '0;
    commit      = pready && pwrite && !err;
    dbg_state_o = (state_q == S_ACCESS);
  end

  // Transfer FSM next state: setup enters ACCESS, completion or abort returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        if (!psel || pready) begin
          state_d = S_IDLE;
        end else if (cnt_q != WAIT_C) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register bank next state: hardware write first so an APB commit to the same index wins.
  always_comb begin
    regs_d = regs_q;
    if (hw_we && ({1'b0, hw_idx} < NREGS_I)) begin
      regs_d[hw_idx] = hw_wdata;
    end
    if (commit) begin
`ifdef APB_REG_PSTRB_EN
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (pstrb[b]) begin
          regs_d[idx][b*8 +: 8] = pwdata[b*8 +: 8];
        end
      end
`else
      regs_d[idx] = pwdata;
`endif
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register bank storage; reset drops any write landing on the same edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flatten the bank so block logic sees every register at once.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// tb_apb_reg_completer: two completers (0 and 2 wait states) share one bus;
// psel is steered to one of them by 'sel'. A register-array reference model
// predicts read data, errors and register contents.
module tb_apb_reg_completer;

  localparam int NR   = 16;
  localparam int BASE = 0;

  // Clock / reset and shared stimulus
  logic        pclk    = 1'b0;
  logic        preset  = 1'b1;
  logic [15:0] paddr   = '0;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [15:0] pwdata  = '0;
`ifdef APB_REG_PSTRB_EN
  logic [1:0]  pstrb   = '0;
`endif
  logic        hw_we    = 1'b0;
  logic [3:0]  hw_idx   = '0;
  logic [15:0] hw_wdata = '0;
  int          sel      = 0;

  logic         psel0, psel1;
  logic [15:0]  prdata0, prdata1;
  logic         pready0, pready1, perror0, perror1, st0, st1;
  logic [255:0] regq0, regq1;

  logic [15:0]  o_prdata;
  logic         o_pready, o_perror, o_state;
  logic [255:0] o_regq;

  // Reference model and scoreboard
  logic [15:0] m [2][NR];
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  assign psel0 = psel && (sel == 0);
  assign psel1 = psel && (sel == 1);

  always_comb begin
    o_prdata = (sel == 0) ? prdata0 : prdata1;
    o_pready = (sel == 0) ? pready0 : pready1;
    o_perror = (sel == 0) ? perror0 : perror1;
    o_state  = (sel == 0) ? st0 : st1;
    o_regq   = (sel == 0) ? regq0 : regq1;
  end

  apb_reg_completer #(.ADDR_W(16), .DATA_W(16), .NUM_REGS(NR), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_REG_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata0), .pready(pready0), .perror(perror0),
    .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata), .reg_q(regq0), .dbg_state_o(st0)
  );

  apb_reg_completer #(.ADDR_W(16), .DATA_W(16), .NUM_REGS(NR), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_dut2 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_REG_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata1), .pready(pready1), .perror(perror1),
    .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata), .reg_q(regq1), .dbg_state_o(st1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [15:0] a);
    int off;
    off = int'(a) - BASE;
    return (off < 0) || (off % 2 != 0) || (off / 2 >= NR);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nd, input logic [1:0] strb);
    logic [15:0] r;
    logic [1:0]  s;
    r = old;
    s = strb;
`ifndef APB_REG_PSTRB_EN
    s = 2'b11;
`endif
    for (int b = 0; b < 2; b++) begin
      if (s[b]) r[b*8 +: 8] = nd[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [255:0] pack(input int s);
    logic [255:0] r;
    for (int i = 0; i < NR; i++) r[i*16 +: 16] = m[s][i];
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) m[k][i] = '0;
  endtask

  // One APB transfer on the selected completer. abort_at: access cycle at which
  // psel is dropped (-1 for none). hw_*: hardware write on the completing edge.
  // rst: assert preset on the completing edge.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      input logic [1:0] strb, input int abort_at, input logic hw_en,
                      input logic [3:0] hw_i, input logic [15:0] hw_d, input logic rst);
    int          w;
    int          ix;
    logic        e;
    logic        aborted;
    logic [15:0] exp_rd;
    w       = (sel == 0) ? 0 : 2;
    e       = addr_err(addr);
    ix      = (int'(addr) - BASE) / 2;
    aborted = 1'b0;
    exp_rd  = '0;
    if (!wr && !e) exp_rd = m[sel][ix];
    exp_q.push_back(exp_rd);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_REG_PSTRB_EN
    pstrb = strb;
`endif
    #1 chk("setup_pready", o_pready, 1'b0);
    for (int c = 0; c <= w && !aborted; c++) begin
      @(negedge pclk);
      if (c == abort_at) begin
        psel = 1'b0; penable = 1'b0; aborted = 1'b1;
        void'(exp_q.pop_front());
      end else begin
        penable = 1'b1;
        if (c == w) begin
          hw_we = hw_en; hw_idx = hw_i; hw_wdata = hw_d; preset = rst;
        end
        #1;
        if (c < w) begin
          chk("wait_pready", o_pready, 1'b0);
          chk("wait_perror", o_perror, 1'b0);
          chk("wait_prdata", o_prdata, 16'h0);
        end else begin
          chk("done_pready", o_pready, 1'b1);
          chk("done_perror", o_perror, e);
          chk("done_prdata", o_prdata, exp_q.pop_front());
        end
      end
    end
    @(posedge pclk);
    if (rst) begin
      clear_model();
    end else if (!aborted) begin
      if (hw_en && int'(hw_i) < NR) begin
        m[0][hw_i] = hw_d;
        m[1][hw_i] = hw_d;
      end
      if (wr && !e) m[sel][ix] = merge(m[sel][ix], data, strb);
    end
    #1;
    hw_we  = 1'b0;
    preset = 1'b0;
    if (rst) begin
      chk("rst_pready", o_pready, 1'b0);
      chk("rst_perror", o_perror, 1'b0);
      chk("rst_prdata", o_prdata, 16'h0);
    end
    psel = 1'b0; penable = 1'b0;
    chk("post_state", o_state, 1'b0);
    chk("post_regq0", regq0, pack(0));
    chk("post_regq1", regq1, pack(1));
  endtask

  task automatic hw_idle(input logic [3:0] i, input logic [15:0] d);
    @(negedge pclk);
    hw_we = 1'b1; hw_idx = i; hw_wdata = d;
    @(posedge pclk);
    m[0][i] = d;
    m[1][i] = d;
    #1 hw_we = 1'b0;
    chk("hw_regq0", regq0, pack(0));
    chk("hw_regq1", regq1, pack(1));
  endtask

  initial begin
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  strb;
    int          ab;
    logic        hen;
    logic [3:0]  hi;
    logic [15:0] hd;

    clear_model();

    // Reset
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_pready", o_pready, 1'b0);
    chk("reset_perror", o_perror, 1'b0);
    chk("reset_prdata", o_prdata, 16'h0);
    chk("reset_state", o_state, 1'b0);
    chk("reset_regq0", regq0, 256'h0);
    chk("reset_regq1", regq1, 256'h0);
    preset = 1'b0;

    // Zero-wait read of register 3
    sel = 0;
    xfer(1'b0, 16'h0006, 16'h0, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b0);

    // Write then read back with two wait states
    sel = 1;
    xfer(1'b1, 16'h0004, 16'hBEEF, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("beef_regq", o_regq[47:32], 16'hBEEF);
    xfer(1'b0, 16'h0004, 16'h0, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b0);

    // Decode errors: unaligned read, out-of-range write
    xfer(1'b0, 16'h0003, 16'h0, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b0);
    xfer(1'b1, 16'h0020, 16'h5A5A, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b0);

    // Same-edge collision, then different-register concurrency
    xfer(1'b1, 16'h000A, 16'h1111, 2'b11, -1, 1'b1, 4'd5, 16'h2222, 1'b0);
    chk("coll_reg5", o_regq[95:80], 16'h1111);
    xfer(1'b1, 16'h000A, 16'h1111, 2'b11, -1, 1'b1, 4'd6, 16'h2222, 1'b0);
    chk("coll2_reg5", o_regq[95:80], 16'h1111);
    chk("coll2_reg6", o_regq[111:96], 16'h2222);

    // Abort mid-wait: no write to register 8
    xfer(1'b1, 16'h0010, 16'h7777, 2'b11, 1, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("abort_reg8", o_regq[143:128], 16'h0);

    // penable without a setup phase is ignored
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0004;
    #1 chk("nosetup_pready", o_pready, 1'b0);
    @(posedge pclk);
    #1 chk("nosetup_state", o_state, 1'b0);
    psel = 1'b0; penable = 1'b0;

    // Reset on the completing write edge
    xfer(1'b1, 16'h0008, 16'h5555, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("rstwr_reg4", o_regq[79:64], 16'h0);

`ifdef APB_REG_PSTRB_EN
    // Byte-lane strobes
    xfer(1'b1, 16'h0004, 16'hAAAA, 2'b11, -1, 1'b0, 4'd0, 16'h0, 1'b0);
    xfer(1'b1, 16'h0004, 16'h1234, 2'b01, -1, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("pstrb_lane", o_regq[47:32], 16'hAA34);
    xfer(1'b1, 16'h0004, 16'hFFFF, 2'b00, -1, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("pstrb_none", o_regq[47:32], 16'hAA34);
`endif

    // Randomized transfers across both completers
    for (int t = 0; t < 80; t++) begin
      sel  = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) addr = 16'($urandom_range(0, 63));
      else                           addr = 16'($urandom_range(0, NR - 1) * 2);
      data = 16'($urandom);
      strb = 2'($urandom);
      if ($urandom_range(0, 5) == 0) ab = int'($urandom_range(0, (sel == 0) ? 0 : 2));
      else                           ab = -1;
      hen  = ($urandom_range(0, 2) == 0);
      hi   = 4'($urandom_range(0, NR - 1));
      hd   = 16'($urandom);
      xfer(wr, addr, data, strb, ab, hen, hi, hd, 1'b0);
      if ($urandom_range(0, 3) == 0) hw_idle(4'($urandom_range(0, NR - 1)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
